// File: rtl/a5_pkg.sv
// Shared constants and state encoding for the A5/1 message path
// (packer, cipher and output unpacker).
package a5_pkg;

   localparam int BLK_BYTES = 32;
   localparam int MSG_W     = 8 * BLK_BYTES;
   localparam int LEN_W     = $clog2(BLK_BYTES + 1);
   localparam int FRM_W     = 22;
   localparam int IDX_W     = $clog2(BLK_BYTES);

   // FILL: collecting bytes into msg; HOLD: presenting a finished block.
   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/a5_msg_packer.sv
// a5_msg_packer: packs a plaintext byte stream into 256-bit zero-padded
// message blocks, first byte in the top byte lane, and tags each block
// with its byte count, end-of-message flag and frame index.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. A source holds data stable while valid=1 and
// ready=0; ready may be sampled as don't-care while valid=0. in_last is only
// meaningful when in_valid=1. msg_valid stays high with msg/msg_len/msg_last/
// frame_cnt frozen until msg_ready is seen.
module a5_msg_packer #(
   parameter int FRM_W = a5_pkg::FRM_W
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [7:0]                in_data,
   input  logic                      in_valid,
   input  logic                      in_last,
   output logic                      in_ready,
   output logic [a5_pkg::MSG_W-1:0]  msg,
   output logic                      msg_valid,
   input  logic                      msg_ready,
   output logic [a5_pkg::LEN_W-1:0]  msg_len,
   output logic                      msg_last,
   output logic [FRM_W-1:0]          frame_cnt
);

   import a5_pkg::*;

   // state is kept as a named signal so checkers can probe the FSM directly.
   state_t           state;
   logic [IDX_W-1:0] idx;

   logic in_fire;
   logic blk_done;

   // A byte is taken when the packer is ready; the block closes on the last
   // byte lane or on the end of the message.
   always_comb begin
      in_fire  = in_valid & in_ready;
      blk_done = in_fire & ((idx == IDX_W'(BLK_BYTES - 1)) | in_last);
   end

   // Packer FSM with byte index, block tags and frame counter, all registered.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= FILL;
         idx       <= '0;
         msg       <= '0;
         msg_valid <= 1'b0;
         in_ready  <= 1'b0;
         msg_len   <= '0;
         msg_last  <= 1'b0;
         frame_cnt <= '0;
      end else begin
         case (state)
            FILL: begin
               in_ready <= 1'b1;
               if (in_fire) begin
                  msg[MSG_W - 1 - 8 * int'(idx) -: 8] <= in_data;
                  idx <= idx + 1'b1;
                  if (blk_done) begin
                     state     <= HOLD;
                     msg_valid <= 1'b1;
                     in_ready  <= 1'b0;
                     msg_len   <= {1'b0, idx} + LEN_W'(1);
                     msg_last  <= in_last;
                  end
               end
            end
            HOLD: begin
               // msg_valid is 1 throughout HOLD, so msg_ready alone completes the transfer.
               if (msg_ready) begin
                  state     <= FILL;
                  msg_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  msg       <= '0;
                  idx       <= '0;
                  frame_cnt <= msg_last ? '0 : frame_cnt + 1'b1;
               end
            end
            default: begin
               state <= FILL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_a5_msg_packer.sv
// Bench for a5_msg_packer: a constant vector table for the short-message
// case, directed multi-cycle sequences, then random traffic against a
// queue-based block model. A second instance with a 4-bit frame counter
// shares every input to exercise frame counter wrap.
module tb_a5_msg_packer;
   import a5_pkg::*;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   in_data;
   logic         in_valid, in_last, msg_ready;
   logic         in_ready, msg_valid, msg_last;
   logic [255:0] msg;
   logic [5:0]   msg_len;
   logic [21:0]  frame_cnt;
   logic         in_ready4, msg_valid4, msg_last4;
   logic [255:0] msg4;
   logic [5:0]   msg_len4;
   logic [3:0]   frame_cnt4;

   always #5 clk = ~clk;

   a5_msg_packer u_dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready), .msg(msg), .msg_valid(msg_valid), .msg_ready(msg_ready),
      .msg_len(msg_len), .msg_last(msg_last), .frame_cnt(frame_cnt)
   );

   a5_msg_packer #(.FRM_W(4)) u_dut4 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
      .in_ready(in_ready4), .msg(msg4), .msg_valid(msg_valid4), .msg_ready(msg_ready),
      .msg_len(msg_len4), .msg_last(msg_last4), .frame_cnt(frame_cnt4)
   );

   // ---------------- reference model ----------------
   logic [7:0]  m_bytes[$];
   bit          m_hold, m_ir, m_init, m_last;
   int unsigned m_frame;
   int          m_len;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          vprob    = 100;
   int          rmode    = 1;   // 0: msg_ready low, 1: high, 2: random

   // snapshot of outputs taken at the falling edge of the last cycle
   logic         s_ir, s_mv, s_last;
   logic [255:0] s_msg;
   logic [5:0]   s_len;
   logic [21:0]  s_frame;
   logic [3:0]   s_frame4;

   function automatic logic [255:0] pack_bytes();
      logic [255:0] v;
      v = '0;
      for (int i = 0; i < m_bytes.size(); i++) v[255 - 8 * i -: 8] = m_bytes[i];
      return v;
   endfunction

   function automatic logic get_mr();
      if (rmode == 0) return 1'b0;
      if (rmode == 1) return 1'b1;
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock cycle: drive, check against the model at negedge, advance the model.
   task automatic cycle(input logic [7:0] d, input logic v, input logic l, input logic mr,
                        input logic r, output bit acc, output bit xfer);
      in_data = d; in_valid = v; in_last = l; msg_ready = mr; rst = r;
      @(negedge clk);
      s_ir = in_ready; s_mv = msg_valid; s_msg = msg; s_len = msg_len;
      s_last = msg_last; s_frame = frame_cnt; s_frame4 = frame_cnt4;
      if (m_init) begin
         chk("in_ready", in_ready, m_ir);
         chk("msg_valid", msg_valid, m_hold);
         chk("msg", msg, pack_bytes());
         chk("msg_len", msg_len, m_len);
         chk("msg_last", msg_last, m_last);
         chk("frame_cnt", frame_cnt, 22'(m_frame));
         chk("frame_cnt4", frame_cnt4, 4'(m_frame));
         chk("in_ready4", in_ready4, m_ir);
         chk("msg4", msg4, pack_bytes());
      end
      acc  = !r && m_ir && v;
      xfer = !r && m_hold && mr;
      @(posedge clk);
      if (r) begin
         m_bytes.delete();
         m_hold = 0; m_ir = 0; m_frame = 0; m_len = 0; m_last = 0; m_init = 1;
      end else begin
         if (acc) begin
            m_bytes.push_back(d);
            if (m_bytes.size() == BLK_BYTES || l) begin
               m_hold = 1; m_len = m_bytes.size(); m_last = l;
            end
         end else if (xfer) begin
            m_bytes.delete();
            m_hold  = 0;
            m_frame = m_last ? 0 : m_frame + 1;
         end
         m_ir = !m_hold;
      end
      #1;
   endtask

   task automatic do_reset(input int n);
      bit a, x;
      for (int i = 0; i < n; i++) cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, a, x);
   endtask

   task automatic send_byte(input logic [7:0] d, input logic l);
      bit acc, x;
      int n;
      acc = 0; n = 0;
      while (!acc && n < 200) begin
         cycle(d, 1'($urandom_range(0, 99) < vprob), l, get_mr(), 1'b0, acc, x);
         n++;
      end
      if (!acc) begin
         n_checks++; n_fail++;
         $display("FAIL send_timeout: byte %0h not accepted within 200 cycles", d);
      end
   endtask

   task automatic drain();
      bit a, x;
      int n;
      n = 0;
      while (m_hold && n < 200) begin
         cycle(8'h00, 1'b0, 1'b0, get_mr(), 1'b0, a, x);
         n++;
      end
      if (m_hold) begin
         n_checks++; n_fail++;
         $display("FAIL drain_timeout: block not taken within 200 cycles");
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0]   d;
      logic         v, l, mr;
      logic         ir, mv;
      logic [255:0] msg;
      logic [5:0]   len;
      logic         last;
      logic [21:0]  frame;
   } vec_t;

   vec_t tbl[9];

   initial begin
      #10_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit a, x;
      int nb;
      bit aborted;

      tbl[0] = '{8'h31, 1, 0, 0, 0, 0, 256'h0, 6'd0, 0, 22'd0};
      tbl[1] = '{8'h31, 1, 0, 0, 1, 0, 256'h0, 6'd0, 0, 22'd0};
      tbl[2] = '{8'h32, 1, 0, 0, 1, 0, {8'h31, 248'h0}, 6'd0, 0, 22'd0};
      tbl[3] = '{8'h33, 1, 0, 0, 1, 0, {16'h3132, 240'h0}, 6'd0, 0, 22'd0};
      tbl[4] = '{8'h34, 1, 0, 0, 1, 0, {24'h313233, 232'h0}, 6'd0, 0, 22'd0};
      tbl[5] = '{8'h35, 1, 1, 0, 1, 0, {32'h31323334, 224'h0}, 6'd0, 0, 22'd0};
      tbl[6] = '{8'hAA, 1, 0, 0, 0, 1, {40'h3132333435, 216'h0}, 6'd5, 1, 22'd0};
      tbl[7] = '{8'h00, 0, 0, 1, 0, 1, {40'h3132333435, 216'h0}, 6'd5, 1, 22'd0};
      tbl[8] = '{8'h00, 0, 0, 0, 1, 0, 256'h0, 6'd5, 1, 22'd0};

      m_init = 0;
      rst = 1; in_data = 0; in_valid = 0; in_last = 0; msg_ready = 0;
      @(posedge clk); #1;
      do_reset(2);

      // Short message "12345" from the table, starting on the first cycle after reset
      for (int i = 0; i < 9; i++) begin
         cycle(tbl[i].d, tbl[i].v, tbl[i].l, tbl[i].mr, 1'b0, a, x);
         chk($sformatf("tbl%0d_in_ready", i), s_ir, tbl[i].ir);
         chk($sformatf("tbl%0d_msg_valid", i), s_mv, tbl[i].mv);
         chk($sformatf("tbl%0d_msg", i), s_msg, tbl[i].msg);
         chk($sformatf("tbl%0d_msg_len", i), s_len, tbl[i].len);
         chk($sformatf("tbl%0d_msg_last", i), s_last, tbl[i].last);
         chk($sformatf("tbl%0d_frame_cnt", i), s_frame, tbl[i].frame);
      end

      // Full block 0x00..0x1F back-to-back
      do_reset(1);
      vprob = 100; rmode = 1;
      for (int i = 0; i < 32; i++) send_byte(8'(i), 1'b0);
      cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, a, x);
      chk("full_msg", s_msg, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
      chk("full_len", s_len, 6'd32);
      chk("full_last", s_last, 1'b0);
      chk("full_valid", s_mv, 1'b1);
      chk("full_frame0", s_frame, 22'd0);
      cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, a, x);
      chk("full_valid_drop", s_mv, 1'b0);
      chk("full_frame1", s_frame, 22'd1);

      // Backpressure: msg_ready low for 10 cycles with in_valid held high
      rmode = 1;
      send_byte(8'h41, 1'b0); send_byte(8'h42, 1'b0); send_byte(8'h43, 1'b1);
      for (int i = 0; i < 10; i++) begin
         cycle(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, a, x);
         chk("bp_valid", s_mv, 1'b1);
         chk("bp_in_ready", s_ir, 1'b0);
         chk("bp_msg", s_msg, {24'h414243, 232'h0});
      end
      cycle(8'h55, 1'b1, 1'b0, 1'b1, 1'b0, a, x);
      send_byte(8'h66, 1'b1);
      cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, a, x);
      chk("bp_next_msg", s_msg, {8'h66, 248'h0});
      chk("bp_next_len", s_len, 6'd1);

      // Reset mid-block, then a block of 0xFF must carry no residue
      for (int i = 0; i < 10; i++) send_byte(8'hA0 + 8'(i), 1'b0);
      do_reset(1);
      for (int i = 0; i < 32; i++) send_byte(8'hFF, 1'b0);
      cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, a, x);
      chk("rst_msg", s_msg, {256{1'b1}});
      chk("rst_len", s_len, 6'd32);
      chk("rst_frame", s_frame, 22'd0);

      // in_last on the 32nd byte
      for (int i = 0; i < 32; i++) send_byte(8'(i * 7), i == 31);
      cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, a, x);
      chk("last32_len", s_len, 6'd32);
      chk("last32_last", s_last, 1'b1);
      chk("last32_frame", s_frame, 22'd1);
      cycle(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, a, x);
      chk("last32_next_frame", s_frame, 22'd0);

      // 17 full blocks without in_last: 4-bit counter wraps on the 17th
      do_reset(1);
      for (int b = 0; b < 17; b++) begin
         for (int i = 0; i < 32; i++) send_byte(8'($urandom), 1'b0);
         cycle(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, a, x);
         chk("wrap_frame4", s_frame4, (b < 16) ? 4'(b) : 4'd0);
         chk("wrap_frame22", s_frame, 22'(b));
      end

      // Random traffic with occasional resets
      vprob = 70; rmode = 2;
      for (int mi = 0; mi < 150; mi++) begin
         nb = $urandom_range(1, 80);
         aborted = 0;
         for (int i = 0; i < nb && !aborted; i++) begin
            if ($urandom_range(0, 99) < 2) begin
               do_reset(1);
               aborted = 1;
            end else begin
               send_byte(8'($urandom), i == nb - 1);
            end
         end
         if ($urandom_range(0, 3) == 0) drain();
      end
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
